store_result_monitor: RTL and testbench
=======================================

# store_result_monitor

Synthesizable end-of-test monitor that sits directly downstream of the pipelined core's data-memory write port (`MemWrite`, `DataAdr`, `WriteData`). It samples every committed store and runs a small verdict state machine: a pass write, an illegal write, or a timeout. It keeps cycle and store counters and a small FIFO log of recent stores, so benches and on-board debug read one registered verdict instead of re-implementing the check.

## Interface
- `PASS_ADDR`, 100: store address that ends the test.
- `PASS_DATA`, 25: data value required at `PASS_ADDR` for a pass.
- `ALLOWED_ADDR`, 96: the only other address the program may store to.
- `TIMEOUT_CYCLES`, 1000: cycles in RUN before the TIMEOUT verdict; must be ≥ 2.
- `LOG_DEPTH`, 4: store-log FIFO entries; must be a power of two, ≥ 2.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; 0 forces the reset state immediately.
- `start`  in  1  leaves IDLE and begins monitoring.
- `clear`  in  1  synchronous return to the reset state.
- `MemWrite`  in  1  store commit strobe from the core.
- `DataAdr`  in  32  store byte address.
- `WriteData`  in  32  store data.
- `done`  out  1  a verdict has been reached.
- `pass`  out  1  verdict PASS.
- `fail`  out  1  verdict FAIL.
- `timeout`  out  1  verdict TIMEOUT.
- `fail_code`  out  2  0 none, 1 illegal address, 2 wrong data at `PASS_ADDR`.
- `cycle_count`  out  32  cycles spent in RUN.
- `write_count`  out  16  stores sampled in RUN; saturates at 0xFFFF.
- `log_valid`  out  1  log FIFO non-empty.
- `log_adr`  out  32  address at the FIFO head.
- `log_data`  out  32  data at the FIFO head.
- `log_rd`  in  1  pops the head when `log_valid` is 1.
- `log_overflow`  out  1  sticky; a store was dropped because the log was full.

## Operation
- States: IDLE, RUN, PASS, FAIL, TIMEOUT. PASS, FAIL and TIMEOUT are terminal.
- Reset state (also the result of `clear`):
  - state IDLE;
  - all flags 0, `fail_code` 0, both counters 0;
  - log empty, `log_overflow` 0.
- IDLE goes to RUN on `start`=1. Stores arriving in IDLE are ignored and not logged.
- RUN, on each edge where `MemWrite`=1 (first matching rule wins):
  - `DataAdr`==`PASS_ADDR` and `WriteData`==`PASS_DATA` → PASS.
  - `DataAdr`==`PASS_ADDR` with other data → FAIL, `fail_code`=2.
  - `DataAdr`!=`ALLOWED_ADDR` → FAIL, `fail_code`=1.
  - Otherwise stay in RUN.
- Every store sampled in RUN increments `write_count` and is pushed to the log. This includes the store that causes a terminal transition.
- RUN with no terminal store and `cycle_count`==`TIMEOUT_CYCLES`-1 → TIMEOUT. A terminal store on the same edge takes priority over the timeout.
- `cycle_count` increments on every edge spent in RUN, including the exiting edge. It freezes in the terminal states and in IDLE.
- Terminal states are sticky and ignore `start` and `MemWrite`. Only `clear` or `reset` leaves them.
- `done` = `pass` | `fail` | `timeout`; at most one verdict flag is ever set.
- `clear` has priority over `start` and over every transition.
- Log FIFO:
  - Head is presented combinationally on `log_adr`/`log_data`.
  - Pointers are `$clog2(LOG_DEPTH)`+1 bits, so full and empty are distinguished.
  - The log keeps its contents in the terminal states, so the store history can be read out after a verdict.
  - Push when full without a simultaneous pop: the store is dropped and `log_overflow` is set. `write_count` still increments.
  - Push and pop together when full: both happen, no overflow.
  - Pop when empty: ignored.

## Timing
- All outputs except the log head come from registers.
- A verdict is visible one edge after the sampling edge: the store sampled at edge N has `pass`=1 after edge N.
- `start` sampled at edge N gives state RUN after edge N. The first store that can be sampled is the one at edge N+1.
- A log push at edge N gives `log_valid`=1 after edge N. A pop at edge N removes the head after edge N.
- `reset` low mid-test clears everything asynchronously. A store present during reset is not sampled.

## Test plan
- Reset, then `start`. Stores of 7 to address 96, then 25 to address 100 → `pass`=1, `done`=1, `write_count`=2, log holds (96,7),(100,25).
- In RUN, store to address 80 → `fail`=1, `fail_code`=1, state sticky; a later store of 25 to address 100 leaves `pass`=0.
- Store of 24 to address 100 → `fail`=1, `fail_code`=2.
- `TIMEOUT_CYCLES`=20, no stores → `timeout`=1 after 20 RUN edges, `cycle_count`=20. Repeat with 25→100 on edge 20 → `pass`=1, `timeout`=0.
- `LOG_DEPTH`=4, six stores to address 96, no reads → `log_overflow`=1, `write_count`=6, four reads return the first four stores, then `log_valid`=0.
- Mid-RUN `reset` low for 3 ns between edges → outputs drop to 0 immediately. `clear` with `start`=1 in PASS → IDLE, flags 0.

Source files
------------

// File: rtl/store_result_monitor_if.sv
// Store-port tap and store-log read port shared by the core side and the monitor.
// MemWrite is a per-edge commit strobe with no backpressure; the log head moves on an
// edge where log_valid and log_rd are both 1, and log_rd while log_valid is 0 is ignored.
interface store_result_monitor_if;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic        log_valid;
  logic [31:0] log_adr;
  logic [31:0] log_data;
  logic        log_rd;

  modport master (
    output MemWrite, DataAdr, WriteData, log_rd,
    input  log_valid, log_adr, log_data
  );

  modport slave (
    input  MemWrite, DataAdr, WriteData, log_rd,
    output log_valid, log_adr, log_data
  );
endinterface

// File: rtl/store_result_monitor.sv
// End-of-test monitor: samples committed stores, reaches a PASS/FAIL/TIMEOUT verdict,
// and keeps cycle/store counters plus a small FIFO log of recent stores.
module store_result_monitor #(
  parameter logic [31:0] PASS_ADDR      = 32'd100,
  parameter logic [31:0] PASS_DATA      = 32'd25,
  parameter logic [31:0] ALLOWED_ADDR   = 32'd96,
  parameter int          TIMEOUT_CYCLES = 1000,
  parameter int          LOG_DEPTH      = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   clear,
  store_result_monitor_if.slave  st,
  output logic                   done,
  output logic                   pass,
  output logic                   fail,
  output logic                   timeout,
  output logic [1:0]             fail_code,
  output logic [31:0]            cycle_count,
  output logic [15:0]            write_count,
  output logic                   log_overflow,
  output logic [2:0]             state_dbg
);

  localparam int          AW          = $clog2(LOG_DEPTH);
  localparam int          PW          = AW + 1;
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_PASS    = 3'd2,
    S_FAIL    = 3'd3,
    S_TIMEOUT = 3'd4
  } state_t;

  state_t      state, nxt_state;
  logic [1:0]  code_r, nxt_code;
  logic        sample;

  // A store counts only while running; clear wins over everything on the same edge.
  assign sample = (state == S_RUN) && st.MemWrite && !clear;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      code_r <= 2'd0;
    end else begin
      state  <= nxt_state;
      code_r <= nxt_code;
    end
  end

  // Next-state logic
  always_comb begin
    nxt_state = state;
    nxt_code  = code_r;
    if (clear) begin
      nxt_state = S_IDLE;
      nxt_code  = 2'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) nxt_state = S_RUN;
        end
        S_RUN: begin
          if (st.MemWrite && (st.DataAdr == PASS_ADDR)) begin
            if (st.WriteData == PASS_DATA) begin
              nxt_state = S_PASS;
            end else begin
              nxt_state = S_FAIL;
              nxt_code  = 2'd2;
            end
          end else if (st.MemWrite && (st.DataAdr != ALLOWED_ADDR)) begin
            nxt_state = S_FAIL;
            nxt_code  = 2'd1;
          end else if (cycle_count == TIMEOUT_LAST) begin
            nxt_state = S_TIMEOUT;
          end
        end
        default: nxt_state = state;
      endcase
    end
  end

  // Output decode
  always_comb begin
    state_dbg = state;
    pass      = (state == S_PASS);
    fail      = (state == S_FAIL);
    timeout   = (state == S_TIMEOUT);
    done      = pass | fail | timeout;
    fail_code = code_r;
  end

  // Counters run only in RUN, including the edge that leaves it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_count <= 32'd0;
      write_count <= 16'd0;
    end else if (clear) begin
      cycle_count <= 32'd0;
      write_count <= 16'd0;
    end else if (state == S_RUN) begin
      cycle_count <= cycle_count + 32'd1;
      if (st.MemWrite && (write_count != 16'hFFFF)) write_count <= write_count + 16'd1;
    end
  end

  // Store log FIFO; the extra pointer bit separates full from empty.
  logic [63:0]   mem [LOG_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          empty, full, pop, push;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = st.log_rd && !empty && !clear;
  assign push  = sample && (!full || pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      log_overflow <= 1'b0;
    end else if (clear) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      log_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (sample && full && !pop) log_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {st.DataAdr, st.WriteData};
  end

  assign st.log_valid = !empty;
  assign st.log_adr   = mem[rd_ptr[AW-1:0]][63:32];
  assign st.log_data  = mem[rd_ptr[AW-1:0]][31:0];

endmodule

// File: tb/tb_store_result_monitor.sv
// Directed bench for store_result_monitor: verdicts and log reads are checked by
// monitors against queues filled by the stimulus; status is checked inline.
module tb_store_result_monitor;
  localparam int T = 20;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        clear = 1'b0;
  logic        done, pass, fail, timeout, log_overflow;
  logic [1:0]  fail_code;
  logic [31:0] cycle_count;
  logic [15:0] write_count;
  logic [2:0]  state_dbg;

  store_result_monitor_if bus ();

  store_result_monitor #(
    .PASS_ADDR(32'd100), .PASS_DATA(32'd25), .ALLOWED_ADDR(32'd96),
    .TIMEOUT_CYCLES(T), .LOG_DEPTH(D)
  ) u_dut (
    .clk(clk), .reset(reset), .start(start), .clear(clear), .st(bus.slave),
    .done(done), .pass(pass), .fail(fail), .timeout(timeout),
    .fail_code(fail_code), .cycle_count(cycle_count), .write_count(write_count),
    .log_overflow(log_overflow), .state_dbg(state_dbg)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [63:0] verdict_q[$];
  logic [63:0] exp_q[$];
  logic        done_seen = 1'b0;

  function automatic logic [63:0] pack_v(logic p, logic f, logic t, logic [1:0] c,
                                         logic [15:0] wc, logic [31:0] cc);
    return {11'd0, p, f, t, c, wc, cc};
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [63:0] e, a;
    if (!done) begin
      done_seen = 1'b0;
    end else if (!done_seen) begin
      done_seen = 1'b1;
      a = pack_v(pass, fail, timeout, fail_code, write_count, cycle_count);
      n_cmp++;
      if (verdict_q.size() == 0) begin
        n_fail++;
        $display("FAIL verdict: unexpected verdict got %0h expected none", a);
      end else begin
        e = verdict_q.pop_front();
        if (a !== e) begin
          n_fail++;
          $display("FAIL verdict: got %0h expected %0h", a, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [63:0] e;
    if (bus.log_valid && bus.log_rd) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL log_head: got %0h/%0h expected no entry", bus.log_adr, bus.log_data);
      end else begin
        e = exp_q.pop_front();
        if ({bus.log_adr, bus.log_data} !== e) begin
          n_fail++;
          $display("FAIL log_head: got %0h/%0h expected %0h/%0h",
                   bus.log_adr, bus.log_data, e[63:32], e[31:0]);
        end
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(logic [31:0] adr, logic [31:0] data);
    bus.MemWrite  = 1'b1;
    bus.DataAdr   = adr;
    bus.WriteData = data;
    tick();
    bus.MemWrite  = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic read_log();
    bus.log_rd = 1'b1;
    tick();
    bus.log_rd = 1'b0;
  endtask

  task automatic check_idle(string name);
    check({name, " flags"}, {58'd0, done, pass, fail, timeout, log_overflow, bus.log_valid}, 64'd0);
    check({name, " code/state"}, {59'd0, fail_code, state_dbg}, 64'd0);
    check({name, " counts"}, {16'd0, cycle_count, write_count}, 64'd0);
  endtask

  // Stimulus
  initial begin
    bus.MemWrite  = 1'b0;
    bus.DataAdr   = 32'd0;
    bus.WriteData = 32'd0;
    bus.log_rd    = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    tick();
    check_idle("reset");

    // Stores in IDLE are ignored
    store(32'd100, 32'd25);
    check_idle("idle store");

    // Pass sequence
    do_start();
    check("start state", state_dbg, 3'd1);
    check("start cycle_count", cycle_count, 32'd0);
    verdict_q.push_back(pack_v(1'b1, 1'b0, 1'b0, 2'd0, 16'd2, 32'd2));
    store(32'd96, 32'd7);
    check("run wc/cc", {write_count, cycle_count}, {16'd1, 32'd1});
    store(32'd100, 32'd25);
    exp_q.push_back({32'd96, 32'd7});
    exp_q.push_back({32'd100, 32'd25});
    read_log();
    read_log();
    check("pass log drained", bus.log_valid, 1'b0);
    check("pass cycle frozen", cycle_count, 32'd2);

    // clear beats start in a terminal state
    clear = 1'b1;
    start = 1'b1;
    tick();
    clear = 1'b0;
    start = 1'b0;
    check_idle("clear in pass");

    // Illegal address, then sticky FAIL
    do_start();
    verdict_q.push_back(pack_v(1'b0, 1'b1, 1'b0, 2'd1, 16'd1, 32'd1));
    store(32'd80, 32'd5);
    store(32'd100, 32'd25);
    do_start();
    check("fail sticky", {pass, fail, state_dbg, write_count}, {1'b0, 1'b1, 3'd3, 16'd1});

    // Wrong data at the pass address
    do_clear();
    do_start();
    verdict_q.push_back(pack_v(1'b0, 1'b1, 1'b0, 2'd2, 16'd1, 32'd1));
    store(32'd100, 32'd24);
    check("wrong data code", fail_code, 2'd2);

    // Timeout after T RUN edges
    do_clear();
    do_start();
    repeat (T - 1) tick();
    check("pre-timeout", {done, cycle_count}, {1'b0, 32'(T - 1)});
    verdict_q.push_back(pack_v(1'b0, 1'b0, 1'b1, 2'd0, 16'd0, 32'(T)));
    tick();
    repeat (3) tick();
    check("timeout frozen", {timeout, cycle_count}, {1'b1, 32'(T)});

    // Pass store on the timeout edge wins
    do_clear();
    do_start();
    repeat (T - 1) tick();
    verdict_q.push_back(pack_v(1'b1, 1'b0, 1'b0, 2'd0, 16'd1, 32'(T)));
    store(32'd100, 32'd25);
    check("pass over timeout", {pass, timeout}, 2'b10);

    // Log overflow
    do_clear();
    do_start();
    for (int i = 1; i <= 6; i++) store(32'd96, 32'(i));
    check("overflow status", {log_overflow, done, write_count}, {1'b1, 1'b0, 16'd6});
    for (int i = 1; i <= D; i++) exp_q.push_back({32'd96, 32'(i)});
    repeat (D) read_log();
    check("overflow log drained", bus.log_valid, 1'b0);

    // Asynchronous reset mid-RUN with a store present
    do_clear();
    do_start();
    store(32'd96, 32'd9);
    check("pre-reset", {bus.log_valid, write_count}, {1'b1, 16'd1});
    bus.MemWrite  = 1'b1;
    bus.DataAdr   = 32'd100;
    bus.WriteData = 32'd25;
    #2 reset = 1'b0;
    #1 check_idle("async reset");
    #2 reset = 1'b1;
    bus.MemWrite = 1'b0;
    tick();
    check_idle("after reset");

    check("verdict queue drained", 64'(verdict_q.size()), 64'd0);
    check("log queue drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
